// File: rtl/micro_branch_control.sv
// micro_branch_control
// Branch-control stage in front of the microprogram sequencer. It evaluates
// the microword's branch condition against a registered flag set, a loop
// counter and external test line. From that it drives the sequencer's
// op/din/offset in the same cycle. It also keeps a shadow of the sequencer's
// 4-deep return stack so that call/return misuse is flagged by sticky errors.
//
// Sequencer op encoding: 0 next, 1 jump, 2 call, 3 return.
// Flag register layout: {V, C, N, Z} = r_flags[3:0].
module micro_branch_control #(
  parameter int AW = 12
) (
  input  logic          clock,
  input  logic          reset,      // asynchronous, active low
  input  logic [2:0]    br,
  input  logic [2:0]    cond_sel,
  input  logic          cond_pol,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    dispatch,
  input  logic [3:0]    flags_in,
  input  logic          flag_we,
  input  logic          ext_test,
  output logic [1:0]    op,
  output logic [AW-1:0] din,
  output logic [AW-1:0] offset,
  output logic          cnt_zero,
  output logic          err_ovf,
  output logic          err_unf
);

  // Branch type codes carried in the microword.
  localparam logic [2:0] BR_CONT     = 3'd0;
  localparam logic [2:0] BR_JUMP     = 3'd1;
  localparam logic [2:0] BR_JCOND    = 3'd2;
  localparam logic [2:0] BR_CALLC    = 3'd3;
  localparam logic [2:0] BR_RETC     = 3'd4;
  localparam logic [2:0] BR_LDCNT    = 3'd5;
  localparam logic [2:0] BR_LOOP     = 3'd6;
  localparam logic [2:0] BR_DISPATCH = 3'd7;

  // Sequencer operation codes.
  localparam logic [1:0] OP_NEXT = 2'd0;
  localparam logic [1:0] OP_JUMP = 2'd1;
  localparam logic [1:0] OP_CALL = 2'd2;
  localparam logic [1:0] OP_RET  = 2'd3;

  // Return-stack capacity of the sequencer being shadowed.
  localparam logic [2:0] STACK_MAX = 3'd4;

  logic [3:0]    r_flags;
  logic [AW-1:0] r_cnt;
  logic [2:0]    r_depth;
  logic          r_err_ovf;
  logic          r_err_unf;

  logic          w_cnt_zero;
  logic          w_raw;
  logic          w_cond;
  logic [1:0]    w_op;
  logic          w_is_dispatch;

  assign w_cnt_zero = (r_cnt == '0);

  // Select the raw condition; flags always come from the register, never from
  // flags_in, so a same-cycle flag load is not visible until the next cycle.
  always_comb begin
    w_raw = 1'b0;
    case (cond_sel)
      3'd0:    w_raw = 1'b1;
      3'd1:    w_raw = r_flags[0];   // Z
      3'd2:    w_raw = r_flags[1];   // N
      3'd3:    w_raw = r_flags[2];   // C
      3'd4:    w_raw = r_flags[3];   // V
      3'd5:    w_raw = w_cnt_zero;
      3'd6:    w_raw = ext_test;
      default: w_raw = 1'b0;
    endcase
  end

  assign w_cond = w_raw ^ cond_pol;

  // Decode branch type into the sequencer operation for this cycle.
  always_comb begin
    w_op          = OP_NEXT;
    w_is_dispatch = 1'b0;
    case (br)
      BR_CONT:     w_op = OP_NEXT;
      BR_JUMP:     w_op = OP_JUMP;
      BR_JCOND:    w_op = w_cond ? OP_JUMP : OP_NEXT;
      BR_CALLC:    w_op = w_cond ? OP_CALL : OP_NEXT;
      BR_RETC:     w_op = w_cond ? OP_RET  : OP_NEXT;
      BR_LDCNT:    w_op = OP_NEXT;
      BR_LOOP:     w_op = w_cnt_zero ? OP_NEXT : OP_JUMP;
      BR_DISPATCH: begin
        w_op          = OP_JUMP;
        w_is_dispatch = 1'b1;
      end
      default:     w_op = OP_NEXT;
    endcase
  end

  // Sequencer-facing outputs are forced quiet while reset is held low, so the
  // sequencer sees a plain "next" with zero address during reset.
  always_comb begin
    op     = OP_NEXT;
    din    = '0;
    offset = '0;
    if (reset) begin
      op  = w_op;
      din = addr;
      if (w_is_dispatch) begin
        offset = {{(AW-4){1'b0}}, dispatch};
      end
    end
  end

  assign cnt_zero = w_cnt_zero;
  assign err_ovf  = r_err_ovf;
  assign err_unf  = r_err_unf;

  // Flag register: loaded independently of the branch type.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_flags <= '0;
    end else if (flag_we) begin
      r_flags <= flags_in;
    end
  end

  // Loop counter: LDCNT loads the address field, LOOP decrements and stops
  // at zero instead of wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (br == BR_LDCNT) begin
      r_cnt <= addr;
    end else if ((br == BR_LOOP) && !w_cnt_zero) begin
      r_cnt <= r_cnt - AW'(1);
    end
  end

  // Return-stack shadow: the depth saturates at 0 and at capacity, and
  // the op that would have gone past either end sets its sticky error.
  // The op is still issued; only the shadow refuses to move.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_depth   <= '0;
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      if (w_op == OP_CALL) begin
        if (r_depth < STACK_MAX) begin
          r_depth <= r_depth + 3'd1;
        end else begin
          r_err_ovf <= 1'b1;
        end
      end else if (w_op == OP_RET) begin
        if (r_depth != 3'd0) begin
          r_depth <= r_depth - 3'd1;
        end else begin
          r_err_unf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_micro_branch_control.sv
// Directed bench for micro_branch_control. Inputs change just after the
// falling edge; combinational outputs are sampled 2 time units later, well
// clear of the rising edge that updates the registered state.
module tb_micro_branch_control;

  logic        clock;
  logic        reset;
  logic [2:0]  br;
  logic [2:0]  cond_sel;
  logic        cond_pol;
  logic [11:0] addr;
  logic [3:0]  dispatch;
  logic [3:0]  flags_in;
  logic        flag_we;
  logic        ext_test;
  logic [1:0]  op;
  logic [11:0] din;
  logic [11:0] offset;
  logic        cnt_zero;
  logic        err_ovf;
  logic        err_unf;

  int checks;
  int failures;

  micro_branch_control #(.AW(12)) dut (
    .clock    (clock),
    .reset    (reset),
    .br       (br),
    .cond_sel (cond_sel),
    .cond_pol (cond_pol),
    .addr     (addr),
    .dispatch (dispatch),
    .flags_in (flags_in),
    .flag_we  (flag_we),
    .ext_test (ext_test),
    .op       (op),
    .din      (din),
    .offset   (offset),
    .cnt_zero (cnt_zero),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: present one microword on the next falling edge, then settle.
  task automatic drive(input logic [2:0] b, input logic [2:0] s, input logic p,
                       input logic [11:0] a, input logic fw, input logic [3:0] fin);
    @(negedge clock);
    br       = b;
    cond_sel = s;
    cond_pol = p;
    addr     = a;
    flag_we  = fw;
    flags_in = fin;
    #2;
  endtask

  task automatic test_reset;
    reset    = 1'b0;
    br       = 3'd1;
    cond_sel = 3'd0;
    cond_pol = 1'b0;
    addr     = 12'h123;
    dispatch = 4'h5;
    flags_in = 4'hF;
    flag_we  = 1'b1;
    ext_test = 1'b0;
    repeat (2) @(negedge clock);
    #2;
    checks++; if (op !== 2'd0) begin failures++; $display("FAIL reset_op got=%0d exp=0", op); end
    checks++; if (din !== 12'h000) begin failures++; $display("FAIL reset_din got=%h exp=000", din); end
    checks++; if (offset !== 12'h000) begin failures++; $display("FAIL reset_offset got=%h exp=000", offset); end
    checks++; if (cnt_zero !== 1'b1) begin failures++; $display("FAIL reset_cnt_zero got=%b exp=1", cnt_zero); end
    checks++; if (err_ovf !== 1'b0 || err_unf !== 1'b0) begin failures++; $display("FAIL reset_errs got=%b%b exp=00", err_ovf, err_unf); end
    @(negedge clock);
    reset   = 1'b1;
    flag_we = 1'b0;
    #2;
    checks++; if (op !== 2'd1) begin failures++; $display("FAIL release_op got=%0d exp=1", op); end
    checks++; if (din !== 12'h123) begin failures++; $display("FAIL release_din got=%h exp=123", din); end
    // Flags were held in reset despite flag_we: Z must read 0.
    drive(3'd2, 3'd1, 1'b0, 12'h020, 1'b0, 4'h0);
    checks++; if (op !== 2'd0) begin failures++; $display("FAIL reset_flags_z got=%0d exp=0", op); end
  endtask

  task automatic test_cond;
    drive(3'd0, 3'd0, 1'b0, 12'h000, 1'b1, 4'b0001);   // load Z=1
    checks++; if (op !== 2'd0) begin failures++; $display("FAIL cont_op got=%0d exp=0", op); end
    drive(3'd2, 3'd1, 1'b0, 12'h040, 1'b1, 4'b0000);   // load Z=0, still sees old Z
    checks++; if (op !== 2'd1) begin failures++; $display("FAIL jcond_z_old got=%0d exp=1", op); end
    checks++; if (din !== 12'h040) begin failures++; $display("FAIL jcond_din got=%h exp=040", din); end
    drive(3'd2, 3'd1, 1'b0, 12'h040, 1'b0, 4'b0000);
    checks++; if (op !== 2'd0) begin failures++; $display("FAIL jcond_z_new got=%0d exp=0", op); end
    drive(3'd2, 3'd1, 1'b1, 12'h040, 1'b0, 4'b0000);
    checks++; if (op !== 2'd1) begin failures++; $display("FAIL jcond_z_inv got=%0d exp=1", op); end
    drive(3'd0, 3'd0, 1'b0, 12'h000, 1'b1, 4'b0010);   // N=1 only
    drive(3'd2, 3'd2, 1'b0, 12'h041, 1'b0, 4'b0000);
    checks++; if (op !== 2'd1) begin failures++; $display("FAIL jcond_n got=%0d exp=1", op); end
    drive(3'd2, 3'd3, 1'b0, 12'h041, 1'b0, 4'b0000);
    checks++; if (op !== 2'd0) begin failures++; $display("FAIL jcond_c got=%0d exp=0", op); end
    drive(3'd0, 3'd0, 1'b0, 12'h000, 1'b1, 4'b1000);   // V=1 only
    drive(3'd2, 3'd4, 1'b0, 12'h042, 1'b0, 4'b0000);
    checks++; if (op !== 2'd1) begin failures++; $display("FAIL jcond_v got=%0d exp=1", op); end
    drive(3'd2, 3'd2, 1'b0, 12'h042, 1'b0, 4'b0000);
    checks++; if (op !== 2'd0) begin failures++; $display("FAIL jcond_n_clear got=%0d exp=0", op); end
    drive(3'd2, 3'd7, 1'b0, 12'h043, 1'b0, 4'b0000);
    checks++; if (op !== 2'd0) begin failures++; $display("FAIL jcond_never got=%0d exp=0", op); end
    drive(3'd2, 3'd7, 1'b1, 12'h043, 1'b0, 4'b0000);
    checks++; if (op !== 2'd1) begin failures++; $display("FAIL jcond_never_inv got=%0d exp=1", op); end
    ext_test = 1'b1;
    drive(3'd2, 3'd6, 1'b0, 12'h044, 1'b0, 4'b0000);
    checks++; if (op !== 2'd1) begin failures++; $display("FAIL jcond_ext1 got=%0d exp=1", op); end
    ext_test = 1'b0;
    #1;
    checks++; if (op !== 2'd0) begin failures++; $display("FAIL jcond_ext0 got=%0d exp=0", op); end
  endtask

  task automatic test_loop;
    logic [1:0] exp_op;
    logic       exp_cz;
    drive(3'd5, 3'd0, 1'b0, 12'h003, 1'b0, 4'h0);
    checks++; if (op !== 2'd0) begin failures++; $display("FAIL ldcnt_op got=%0d exp=0", op); end
    checks++; if (cnt_zero !== 1'b1) begin failures++; $display("FAIL ldcnt_cz got=%b exp=1", cnt_zero); end
    for (int i = 0; i < 5; i++) begin
      exp_op = (i < 3) ? 2'd1 : 2'd0;
      exp_cz = (i >= 3);
      drive(3'd6, 3'd7, 1'b0, 12'h055, 1'b0, 4'h0);    // cond_sel ignored by LOOP
      checks++; if (op !== exp_op) begin failures++; $display("FAIL loop_op[%0d] got=%0d exp=%0d", i, op, exp_op); end
      checks++; if (cnt_zero !== exp_cz) begin failures++; $display("FAIL loop_cz[%0d] got=%b exp=%b", i, cnt_zero, exp_cz); end
      checks++; if (din !== 12'h055) begin failures++; $display("FAIL loop_din[%0d] got=%h exp=055", i, din); end
    end
    drive(3'd2, 3'd5, 1'b0, 12'h066, 1'b0, 4'h0);
    checks++; if (op !== 2'd1) begin failures++; $display("FAIL jcond_cz got=%0d exp=1", op); end
  endtask

  task automatic test_dispatch;
    dispatch = 4'hA;
    drive(3'd7, 3'd0, 1'b0, 12'h100, 1'b0, 4'h0);
    checks++; if (op !== 2'd1) begin failures++; $display("FAIL disp_op got=%0d exp=1", op); end
    checks++; if (din !== 12'h100) begin failures++; $display("FAIL disp_din got=%h exp=100", din); end
    checks++; if (offset !== 12'h00A) begin failures++; $display("FAIL disp_offset got=%h exp=00a", offset); end
    dispatch = 4'hF;
    drive(3'd7, 3'd0, 1'b0, 12'hFF0, 1'b0, 4'h0);
    checks++; if (offset !== 12'h00F) begin failures++; $display("FAIL disp_offset_f got=%h exp=00f", offset); end
    drive(3'd1, 3'd0, 1'b0, 12'h321, 1'b0, 4'h0);
    checks++; if (offset !== 12'h000) begin failures++; $display("FAIL jump_offset got=%h exp=000", offset); end
    checks++; if (op !== 2'd1) begin failures++; $display("FAIL jump_op got=%0d exp=1", op); end
  endtask

  task automatic test_stack;
    for (int i = 0; i < 5; i++) begin
      drive(3'd3, 3'd0, 1'b0, 12'h200 + 12'(i), 1'b0, 4'h0);
      checks++; if (op !== 2'd2) begin failures++; $display("FAIL call_op[%0d] got=%0d exp=2", i, op); end
      checks++; if (err_ovf !== 1'b0) begin failures++; $display("FAIL call_ovf[%0d] got=%b exp=0", i, err_ovf); end
    end
    drive(3'd3, 3'd7, 1'b0, 12'h210, 1'b0, 4'h0);     // condition false
    checks++; if (op !== 2'd0) begin failures++; $display("FAIL callc_false got=%0d exp=0", op); end
    checks++; if (err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", err_ovf); end
    for (int i = 0; i < 5; i++) begin
      drive(3'd4, 3'd0, 1'b0, 12'h000, 1'b0, 4'h0);
      checks++; if (op !== 2'd3) begin failures++; $display("FAIL ret_op[%0d] got=%0d exp=3", i, op); end
      checks++; if (err_unf !== 1'b0) begin failures++; $display("FAIL ret_unf[%0d] got=%b exp=0", i, err_unf); end
    end
    drive(3'd0, 3'd0, 1'b0, 12'h000, 1'b0, 4'h0);
    checks++; if (err_unf !== 1'b1) begin failures++; $display("FAIL unf_set got=%b exp=1", err_unf); end
    drive(3'd1, 3'd0, 1'b0, 12'h000, 1'b0, 4'h0);
    checks++; if (err_ovf !== 1'b1 || err_unf !== 1'b1) begin failures++; $display("FAIL errs_sticky got=%b%b exp=11", err_ovf, err_unf); end
  endtask

  task automatic test_reset_mid;
    drive(3'd3, 3'd0, 1'b0, 12'h300, 1'b0, 4'h0);     // depth 0 -> 1
    drive(3'd5, 3'd0, 1'b0, 12'h004, 1'b0, 4'h0);
    drive(3'd6, 3'd0, 1'b0, 12'h080, 1'b0, 4'h0);     // 4 -> 3
    drive(3'd6, 3'd0, 1'b0, 12'h080, 1'b0, 4'h0);     // 3 -> 2
    drive(3'd6, 3'd0, 1'b0, 12'h080, 1'b0, 4'h0);     // counter = 2 here
    checks++; if (op !== 2'd1 || cnt_zero !== 1'b0) begin failures++; $display("FAIL mid_loop got=op%0d cz%b exp=op1 cz0", op, cnt_zero); end
    #1;
    reset = 1'b0;                                      // no clock edge near
    #1;
    checks++; if (cnt_zero !== 1'b1) begin failures++; $display("FAIL mid_rst_cz got=%b exp=1", cnt_zero); end
    checks++; if (err_ovf !== 1'b0 || err_unf !== 1'b0) begin failures++; $display("FAIL mid_rst_errs got=%b%b exp=00", err_ovf, err_unf); end
    checks++; if (op !== 2'd0 || din !== 12'h000) begin failures++; $display("FAIL mid_rst_out got=op%0d din%h exp=op0 din000", op, din); end
    @(negedge clock);
    reset = 1'b1;
    drive(3'd6, 3'd0, 1'b0, 12'h080, 1'b0, 4'h0);
    checks++; if (op !== 2'd0 || cnt_zero !== 1'b1) begin failures++; $display("FAIL post_rst_loop got=op%0d cz%b exp=op0 cz1", op, cnt_zero); end
    drive(3'd4, 3'd0, 1'b0, 12'h000, 1'b0, 4'h0);     // return at depth 0
    checks++; if (op !== 2'd3) begin failures++; $display("FAIL post_rst_ret got=%0d exp=3", op); end
    drive(3'd0, 3'd0, 1'b0, 12'h000, 1'b0, 4'h0);
    checks++; if (err_unf !== 1'b1 || err_ovf !== 1'b0) begin failures++; $display("FAIL post_rst_depth got=%b%b exp=01", err_ovf, err_unf); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset;
    test_cond;
    test_loop;
    test_dispatch;
    test_stack;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
